orb_frame_ctrl: RTL and testbench
=================================

Name: orb_frame_ctrl

Overview:
Frame-level sequencer in front of the ORB keypoint chip. On request it reads one WIDTH×HEIGHT frame from pixel memory and streams it into the chip at one pixel per cycle with no gaps, pulsing the chip's start strobe on pixel 0. It then counts the keypoint flags the chip emits and waits for the chip's end-of-frame, with a drain watchdog. It finally reports completion with the keypoint count and error status.

Parameters:
WIDTH, 640, pixels per row
HEIGHT, 480, rows per frame
ADDR_W, 19, pixel memory address width
MEM_LAT, 1, fixed memory read latency in cycles (1..4)
MAX_KP, 1023, keypoint count saturation limit
KP_W, 10, width of keypoint counter (must hold MAX_KP)
DRAIN_MAX, 65535, cycles allowed after last pixel for chip end
DRAIN_W, 16, drain counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_req  in  1  start-frame request; accepted only in IDLE
i_base_addr  in  ADDR_W  frame base address, sampled when i_req is accepted
o_busy  out  1  high from accept until the DONE cycle (inclusive)
o_done  out  1  one-cycle completion pulse
o_kp_count  out  KP_W  keypoints counted in last/current frame
o_overflow  out  1  more than MAX_KP flags seen
o_timeout  out  1  chip end not seen within DRAIN_MAX
o_mem_rd  out  1  memory read strobe
o_mem_addr  out  ADDR_W  memory read address
i_mem_data  in  8  read data, valid MEM_LAT cycles after o_mem_rd
o_pixel  out  8  pixel to chip
o_chip_start  out  1  high with pixel 0 only
i_chip_flag  in  1  chip keypoint valid
i_chip_end  in  1  chip end-of-frame
o_kp_accept  out  1  combinational: i_chip_flag && counting && count<MAX_KP

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0: o_pixel, o_mem_addr, o_kp_count, flags, o_busy, o_done, o_chip_start.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: o_busy=0. On i_req:
  - latch base;
  - clear o_kp_count, o_overflow, o_timeout;
  - go to STREAM.
  - i_req is ignored in every other state.
- STREAM: o_mem_rd=1 every cycle. o_mem_addr = base + k for k = 0..N-1, with N = WIDTH*HEIGHT. Addition is modulo 2^ADDR_W, so the address wraps silently. After read N-1 is issued, go to DRAIN.
- Pixel pipeline:
  - A read-valid shift register of depth MEM_LAT tracks outstanding reads.
  - o_pixel is registered: pixel k appears MEM_LAT+1 cycles after read k is issued. Consecutive pixels are on consecutive cycles.
  - o_chip_start=1 exactly in the cycle o_pixel carries pixel 0.
  - o_pixel=0 whenever no valid pixel is present.
- DRAIN: no reads. The pipeline flushes the remaining pixels. The drain counter starts at 0 in the cycle after the last pixel is output and increments each cycle. Counter reaching DRAIN_MAX → set o_timeout, go to DONE.
- i_chip_end in STREAM or DRAIN → DONE. End arriving before the last pixel is output is accepted; remaining pixels are discarded and o_pixel forced to 0.
- DONE: o_done=1 and o_busy=1 for one cycle, then IDLE.
- Counting is active in STREAM and DRAIN, including the cycle i_chip_end is seen.
  - Each i_chip_flag increments o_kp_count while count < MAX_KP.
  - A flag arriving at count == MAX_KP sets o_overflow (sticky); the count stays at MAX_KP.
  - Flag and end in the same cycle: the flag is counted.
- o_kp_count, o_overflow and o_timeout hold after DONE until the next accepted i_req.
- Flags in IDLE/DONE are ignored; o_kp_accept=0 there.
- Reset mid-frame: immediate return to IDLE, outputs cleared, no o_done.

Test Plan:
- WIDTH=8, HEIGHT=4, MEM_LAT=1, base=0x100, memory[a]=a[7:0], req at cycle 0:
  - reads 0x100..0x11F issued on cycles 1..32;
  - o_chip_start + o_pixel=0x00 on cycle 3;
  - o_pixel=0x1F on cycle 34;
  - chip_end on cycle 40 → o_done on cycle 41.
- Same frame, 5 flags spread over STREAM/DRAIN, last one coincident with chip_end → o_kp_count=5, o_overflow=0, o_timeout=0.
- MAX_KP=3, 5 flags → o_kp_count=3, o_overflow=1, o_kp_accept high on first 3 flags only.
- DRAIN_MAX=10, chip_end never asserted → o_timeout=1 and o_done 11 cycles after last pixel; kp state holds until next req, which clears it.
- base=2^ADDR_W-4 → addresses wrap to 0..27 after 4 reads.
- MEM_LAT=3: pixel 0 lands 4 cycles after first read.
- i_req during STREAM is ignored.
- rst_n low in STREAM: all outputs 0 asynchronously, no o_done.
- A new req after reset streams from pixel 0.

Source files
------------

// File: rtl/orb_frame_ctrl.sv
// rtl/orb_frame_ctrl.sv - frame sequencer streaming pixel memory into the ORB chip
module orb_frame_ctrl #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int ADDR_W    = 19,
  parameter int MEM_LAT   = 1,
  parameter int MAX_KP    = 1023,
  parameter int KP_W      = 10,
  parameter int DRAIN_MAX = 65535,
  parameter int DRAIN_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [KP_W-1:0]   o_kp_count,
  output logic              o_overflow,
  output logic              o_timeout,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pixel,
  output logic              o_chip_start,
  input  logic              i_chip_flag,
  input  logic              i_chip_end,
  output logic              o_kp_accept
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [MEM_LAT-1:0]  vld_q, vld_d;
  logic [MEM_LAT-1:0]  first_q, first_d;
  logic [7:0]          pix_q, pix_d;
  logic                pix_vld_q, pix_vld_d;
  logic                start_q, start_d;
  logic [KP_W-1:0]     kp_q, kp_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic active;
  logic rd;
  logic flush;
  logic drain_run;
  logic kp_accept;

  // State register and datapath flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      vld_q     <= '0;
      first_q   <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      start_q   <= 1'b0;
      kp_q      <= '0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      pix_q     <= pix_d;
      pix_vld_q <= pix_vld_d;
      start_q   <= start_d;
      kp_q      <= kp_d;
      ovf_q     <= ovf_d;
      to_q      <= to_d;
      drain_q   <= drain_d;
    end
  end

  // Next-state, read pipeline, drain watchdog and keypoint counting
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    kp_d      = kp_q;
    ovf_d     = ovf_q;
    to_d      = to_q;
    drain_d   = drain_q;
    vld_d     = '0;
    first_d   = '0;

    active    = (state_q == STREAM) || (state_q == DRAIN);
    rd        = (state_q == STREAM);
    // An end from the chip discards whatever is still in flight.
    flush     = !active || i_chip_end;
    kp_accept = i_chip_flag && active && (kp_q < KP_W'(MAX_KP));

    // Watchdog only runs once the last pixel has left the output register.
    drain_run = (state_q == DRAIN) && (vld_q == '0) && !pix_vld_q;

    if (!flush) begin
      vld_d[0]   = rd;
      first_d[0] = rd && (rd_cnt_q == '0);
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_d[i]   = vld_q[i-1];
        first_d[i] = first_q[i-1];
      end
    end

    pix_vld_d = !flush && vld_q[MEM_LAT-1];
    pix_d     = pix_vld_d ? i_mem_data : 8'h00;
    start_d   = pix_vld_d && first_q[MEM_LAT-1];

    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d  = STREAM;
          addr_d   = i_base_addr;
          rd_cnt_d = '0;
          kp_d     = '0;
          ovf_d    = 1'b0;
          to_d     = 1'b0;
          drain_d  = '0;
        end
      end
      STREAM: begin
        addr_d   = addr_q + ADDR_W'(1);
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (rd_cnt_q == CNT_W'(N - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_run) begin
          if (drain_q == DRAIN_W'(DRAIN_MAX - 1)) begin
            to_d    = 1'b1;
            state_d = DONE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (active && i_chip_end) begin
      state_d = DONE;
    end

    // A flag in the end cycle is still counted.
    if (active && i_chip_flag) begin
      if (kp_accept) begin
        kp_d = kp_q + KP_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_kp_count   = kp_q;
  assign o_overflow   = ovf_q;
  assign o_timeout    = to_q;
  assign o_mem_rd     = rd;
  assign o_mem_addr   = addr_q;
  assign o_pixel      = pix_q;
  assign o_chip_start = start_q;
  assign o_kp_accept  = kp_accept;

endmodule

// File: tb/tb_orb_frame_ctrl.sv
// tb/tb_orb_frame_ctrl.sv - self-checking bench for orb_frame_ctrl
module tb_orb_frame_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req[2];
  logic [18:0] base[2];
  logic        flag[2];
  logic        cend[2];
  logic [7:0]  mdat[2];
  logic        busy[2];
  logic        done[2];
  logic        ovf[2];
  logic        to[2];
  logic        rd[2];
  logic        start[2];
  logic        acc[2];
  logic [9:0]  kp[2];
  logic [18:0] addr[2];
  logic [7:0]  pix[2];
  int          last_kp[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  orb_frame_ctrl #(.WIDTH(8), .HEIGHT(4), .ADDR_W(19), .MEM_LAT(1), .MAX_KP(1023),
                   .KP_W(10), .DRAIN_MAX(10), .DRAIN_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_base_addr(base[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_kp_count(kp[0]), .o_overflow(ovf[0]),
    .o_timeout(to[0]), .o_mem_rd(rd[0]), .o_mem_addr(addr[0]), .i_mem_data(mdat[0]),
    .o_pixel(pix[0]), .o_chip_start(start[0]), .i_chip_flag(flag[0]),
    .i_chip_end(cend[0]), .o_kp_accept(acc[0]));

  orb_frame_ctrl #(.WIDTH(8), .HEIGHT(4), .ADDR_W(19), .MEM_LAT(3), .MAX_KP(3),
                   .KP_W(10), .DRAIN_MAX(10), .DRAIN_W(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_base_addr(base[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_kp_count(kp[1]), .o_overflow(ovf[1]),
    .o_timeout(to[1]), .o_mem_rd(rd[1]), .o_mem_addr(addr[1]), .i_mem_data(mdat[1]),
    .o_pixel(pix[1]), .o_chip_start(start[1]), .i_chip_flag(flag[1]),
    .i_chip_end(cend[1]), .o_kp_accept(acc[1]));

  // Pixel memory: mem[a] = a[7:0], latency 1 for u_a and 3 for u_b
  logic [7:0] mp0;
  logic [7:0] mp1[3];
  always @(posedge clk) begin
    mp0    <= rd[0] ? addr[0][7:0] : 8'h00;
    mp1[0] <= rd[1] ? addr[1][7:0] : 8'h00;
    mp1[1] <= mp1[0];
    mp1[2] <= mp1[1];
  end
  assign mdat[0] = mp0;
  assign mdat[1] = mp1[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string name);
    chk(name, {busy[d], done[d], ovf[d], to[d], rd[d], start[d], acc[d],
               kp[d], addr[d], pix[d]}, 64'd0);
  endtask

  // Scoreboard of expected reads and pixels, keyed by cycle
  typedef struct {
    int          d;
    int          c;
    logic [18:0] a;
    logic [7:0]  p;
    logic        st;
  } ev_t;
  ev_t rq[$];
  ev_t pq[$];

  always @(negedge clk) begin
    ev_t e;
    while (rq.size() > 0 && rq[0].c <= cyc) begin
      e = rq.pop_front();
      chk("mem_rd", rd[e.d], 1);
      chk("mem_addr", addr[e.d], e.a);
    end
    while (pq.size() > 0 && pq[0].c <= cyc) begin
      e = pq.pop_front();
      chk("pixel", pix[e.d], e.p);
      chk("chip_start", start[e.d], e.st);
    end
  end

  // Frame scenarios: stimulus plus expected outcome
  typedef struct {
    int          d;
    logic [18:0] base;
    int          fl[5];
    int          end_rel;
    int          req2;
    int          exp_kp;
    bit          exp_ovf;
    bit          exp_to;
    int          exp_done;
  } sc_t;
  sc_t tab[5];

  task automatic run(input int s);
    sc_t         t;
    int          d, lat, maxk, c0, done_rel, pulses, ekp;
    bit          fl_now, win;
    logic [18:0] a;
    t = tab[s];
    d = t.d;
    lat = (d == 1) ? 3 : 1;
    maxk = (d == 1) ? 3 : 1023;
    ekp = 0;
    c0 = 0;
    done_rel = -1;
    pulses = 0;
    for (int rel = 0; rel <= t.exp_done + 6; rel++) begin
      @(negedge clk);
      if (rel == 0) begin
        c0 = cyc;
        chk("idle_busy", busy[d], 0);
        chk("kp_hold", kp[d], last_kp[d]);
        for (int k = 0; k < N; k++) begin
          a = t.base + 19'(k);
          if (t.end_rel < 0 || 1 + k <= t.end_rel)
            rq.push_back('{d, c0 + 1 + k, a, 8'h00, 1'b0});
          if (t.end_rel < 0 || lat + 2 + k <= t.end_rel)
            pq.push_back('{d, c0 + lat + 2 + k, 19'd0, a[7:0], (k == 0)});
        end
      end
      if (rel == 1) begin
        chk("accept_busy", busy[d], 1);
        chk("clear_kp", kp[d], 0);
        chk("clear_ovf", ovf[d], 0);
        chk("clear_to", to[d], 0);
      end
      if (rel == N + 1 && (t.end_rel < 0 || t.end_rel > N + 1))
        chk("drain_no_rd", rd[d], 0);
      if (done[d]) begin
        pulses++;
        if (done_rel < 0) done_rel = rel;
        chk("done_busy", busy[d], 1);
      end
      req[d]  = (rel == 0) || (rel == t.req2);
      base[d] = t.base;
      cend[d] = (rel == t.end_rel);
      fl_now = 1'b0;
      for (int i = 0; i < 5; i++) if (t.fl[i] == rel) fl_now = 1'b1;
      flag[d] = fl_now;
      #1;
      if (fl_now) begin
        win = (rel >= 1) && (rel < t.exp_done);
        chk("kp_accept", acc[d], win && (ekp < maxk));
        if (win && ekp < maxk) ekp++;
      end
    end
    req[d] = 1'b0;
    cend[d] = 1'b0;
    flag[d] = 1'b0;
    chk("done_cycle", done_rel, t.exp_done);
    chk("done_pulses", pulses, 1);
    chk("kp_count", kp[d], t.exp_kp);
    chk("overflow", ovf[d], t.exp_ovf);
    chk("timeout", to[d], t.exp_to);
    chk("idle_after", busy[d], 0);
    last_kp[d] = t.exp_kp;
  endtask

  initial begin
    tab[0] = '{0, 19'h00100, '{5, 10, 20, 36, 40}, 40, 10, 5, 1'b0, 1'b0, 41};
    tab[1] = '{0, 19'h7FFFC, '{50, -1, -1, -1, -1}, -1, -1, 0, 1'b0, 1'b1, 45};
    tab[2] = '{0, 19'h00000, '{0, 2, 3, -1, -1}, 20, -1, 2, 1'b0, 1'b0, 21};
    tab[3] = '{1, 19'h00040, '{2, 4, 6, 8, 9}, 30, -1, 3, 1'b1, 1'b0, 31};
    tab[4] = '{1, 19'h00200, '{-1, -1, -1, -1, -1}, -1, -1, 0, 1'b0, 1'b1, 47};

    rst_n = 1'b0;
    last_kp[0] = 0;
    last_kp[1] = 0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; base[d] = '0; flag[d] = 1'b0; cend[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    rst_n = 1'b1;

    for (int s = 0; s < 5; s++) run(s);

    // Reset in the middle of a frame
    @(negedge clk);
    req[0] = 1'b1;
    base[0] = 19'h00100;
    @(negedge clk);
    req[0] = 1'b0;
    flag[0] = 1'b1;
    @(negedge clk);
    flag[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_rd", rd[0], 1);
    chk("pre_rst_kp", kp[0], 1);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done[0], 0);
    end
    rst_n = 1'b1;
    last_kp[0] = 0;

    // Fresh frame after reset starts from pixel 0
    run(0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
